// File: rtl/operand_matcher_pkg.sv
// Shared sizing, in_result field layout and sequencer state encoding for the
// operand matcher / pair sequencer path.
package operand_matcher_pkg;

    localparam int BITMASK_LENGTH    = 8;
    localparam int INDEX_BITWIDTH    = 3;
    localparam int WORD_WIDTH        = 64;
    localparam int INDEX_FIELD_WIDTH = BITMASK_LENGTH * INDEX_BITWIDTH;

    localparam int ACT_LSB  = 0;
    localparam int WGT_LSB  = ACT_LSB + INDEX_FIELD_WIDTH;
    localparam int MASK_LSB = WGT_LSB + INDEX_FIELD_WIDTH;
    localparam int PAD_LSB  = MASK_LSB + BITMASK_LENGTH;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_EMIT = 1'b1
    } seq_state_t;

endpackage

// File: rtl/lowest_slot_finder.sv
// Combinational priority search: index of the lowest set bit of mask.
module lowest_slot_finder #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0]         mask,
    output logic [$clog2(WIDTH)-1:0] slot,
    output logic                     any_set
);

    localparam int SW = $clog2(WIDTH);

    always_comb begin
        slot    = '0;
        any_set = 1'b0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (mask[i] && !any_set) begin
                slot    = SW'(i);
                any_set = 1'b1;
            end
        end
    end

endmodule

// File: rtl/operand_pair_sequencer.sv
// Expands one matcher result word into a stream of (activation, weight) index
// pairs, one per set bitmask slot, or a single empty beat for a zero mask.
module operand_pair_sequencer #(
    parameter int BITMASK_LENGTH = operand_matcher_pkg::BITMASK_LENGTH,
    parameter int INDEX_BITWIDTH = operand_matcher_pkg::INDEX_BITWIDTH
) (
    input  logic                                      clock,
    input  logic                                      resetn,
    input  logic                                      in_valid,
    output logic                                      in_ready,
    input  logic [operand_matcher_pkg::WORD_WIDTH-1:0] in_result,
    output logic                                      out_valid,
    input  logic                                      out_ready,
    output logic [INDEX_BITWIDTH-1:0]                 out_act_index,
    output logic [INDEX_BITWIDTH-1:0]                 out_wgt_index,
    output logic                                      out_last,
    output logic                                      out_empty,
    output logic                                      busy
);

    import operand_matcher_pkg::*;

    localparam int SLOT_W  = $clog2(BITMASK_LENGTH);
    localparam int FIELD_W = BITMASK_LENGTH * INDEX_BITWIDTH;

    seq_state_t                state;
    logic [BITMASK_LENGTH-1:0] pend_mask, sel_mask, slot_bit, rest_mask;
    logic [FIELD_W-1:0]        pend_act, pend_wgt, sel_act, sel_wgt;
    logic [SLOT_W-1:0]         slot;
    logic                      any_set;
    logic                      in_fire, out_fire;
    logic [INDEX_BITWIDTH-1:0] nxt_act, nxt_wgt;
    logic                      pad_unused;

    assign pad_unused = ^in_result[WORD_WIDTH-1:PAD_LSB];

    assign in_ready = resetn && ((state == ST_IDLE) || (out_valid && out_ready && out_last));
    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;
    assign busy     = (state == ST_EMIT);

    // The pending mask holds only slots not yet presented, so the beat loaded
    // into the output register is already removed from it; the search runs on
    // the incoming word when loading and on the pending mask otherwise.
    always_comb begin
        sel_mask = in_fire ? in_result[MASK_LSB +: BITMASK_LENGTH] : pend_mask;
        sel_act  = in_fire ? in_result[ACT_LSB +: FIELD_W] : pend_act;
        sel_wgt  = in_fire ? in_result[WGT_LSB +: FIELD_W] : pend_wgt;
        slot_bit       = '0;
        slot_bit[slot] = any_set;
        rest_mask      = sel_mask & ~slot_bit;
        nxt_act = any_set ? sel_act[slot * INDEX_BITWIDTH +: INDEX_BITWIDTH] : '0;
        nxt_wgt = any_set ? sel_wgt[slot * INDEX_BITWIDTH +: INDEX_BITWIDTH] : '0;
    end

    lowest_slot_finder #(
        .WIDTH(BITMASK_LENGTH)
    ) u_finder (
        .mask    (sel_mask),
        .slot    (slot),
        .any_set (any_set)
    );

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state         <= ST_IDLE;
            pend_mask     <= '0;
            pend_act      <= '0;
            pend_wgt      <= '0;
            out_valid     <= 1'b0;
            out_last      <= 1'b0;
            out_empty     <= 1'b0;
            out_act_index <= '0;
            out_wgt_index <= '0;
        end else if (in_fire) begin
            state         <= ST_EMIT;
            pend_mask     <= rest_mask;
            pend_act      <= sel_act;
            pend_wgt      <= sel_wgt;
            out_valid     <= 1'b1;
            out_last      <= (rest_mask == '0);
            out_empty     <= !any_set;
            out_act_index <= nxt_act;
            out_wgt_index <= nxt_wgt;
        end else if (out_fire) begin
            if (out_last) begin
                state         <= ST_IDLE;
                out_valid     <= 1'b0;
                out_last      <= 1'b0;
                out_empty     <= 1'b0;
                out_act_index <= '0;
                out_wgt_index <= '0;
            end else begin
                pend_mask     <= rest_mask;
                out_last      <= (rest_mask == '0);
                out_empty     <= 1'b0;
                out_act_index <= nxt_act;
                out_wgt_index <= nxt_wgt;
            end
        end
    end

endmodule

// File: tb/tb_operand_pair_sequencer.sv
// Directed bench for operand_pair_sequencer: fixed words with hand-computed beats.
module tb_operand_pair_sequencer;

    logic        clock;
    logic        resetn;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_result;
    logic        out_valid;
    logic        out_ready;
    logic [2:0]  out_act_index;
    logic [2:0]  out_wgt_index;
    logic        out_last;
    logic        out_empty;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    operand_pair_sequencer #(
        .BITMASK_LENGTH(8),
        .INDEX_BITWIDTH(3)
    ) dut (
        .clock         (clock),
        .resetn        (resetn),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_result     (in_result),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_act_index (out_act_index),
        .out_wgt_index (out_wgt_index),
        .out_last      (out_last),
        .out_empty     (out_empty),
        .busy          (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Beat snapshot: {valid, last, empty, act[2:0], wgt[2:0]}
    function automatic logic [8:0] beat();
        return {out_valid, out_last, out_empty, out_act_index, out_wgt_index};
    endfunction

    function automatic logic [8:0] exp_beat(input logic v, input logic l, input logic e,
                                            input logic [2:0] a, input logic [2:0] w);
        return {v, l, e, a, w};
    endfunction

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        resetn    = 1'b0;
        in_valid  = 1'b0;
        in_result = '0;
        out_ready = 1'b1;
        #2;
        n_checks++;
        if (beat() !== 9'h000) begin
            n_fail++;
            $display("FAIL reset.outputs: got %h expected 000", beat());
        end
        n_checks++;
        if ({busy, in_ready} !== 2'b00) begin
            n_fail++;
            $display("FAIL reset.busy_ready: got %b expected 00", {busy, in_ready});
        end
        repeat (2) @(posedge clock);
        #3 resetn = 1'b1;
        #1;
        n_checks++;
        if ({busy, in_ready} !== 2'b01) begin
            n_fail++;
            $display("FAIL reset.release_ready: got %b expected 01", {busy, in_ready});
        end
        next_cycle();
    endtask

    // mask 0x07, act 1,4,6, wgt 2,3,7; unused slots filled with 7 / pad garbage
    task automatic test_three_beats();
        logic [8:0] exp [3];
        exp[0] = exp_beat(1'b1, 1'b0, 1'b0, 3'd1, 3'd2);
        exp[1] = exp_beat(1'b1, 1'b0, 1'b0, 3'd4, 3'd3);
        exp[2] = exp_beat(1'b1, 1'b1, 1'b0, 3'd6, 3'd7);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_result = {8'hA5, 8'h07, {15'h7FFF, 3'd7, 3'd3, 3'd2}, {15'h7FFF, 3'd6, 3'd4, 3'd1}};
        n_checks++;
        if ({in_ready, out_valid} !== 2'b10) begin
            n_fail++;
            $display("FAIL three.accept: got %b expected 10", {in_ready, out_valid});
        end
        next_cycle();
        in_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            n_checks++;
            if (beat() !== exp[k]) begin
                n_fail++;
                $display("FAIL three.beat%0d: got %h expected %h", k, beat(), exp[k]);
            end
            next_cycle();
        end
        n_checks++;
        if ({out_valid, busy, in_ready} !== 3'b001) begin
            n_fail++;
            $display("FAIL three.idle: got %b expected 001", {out_valid, busy, in_ready});
        end
    endtask

    task automatic test_empty();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_result = {8'hFF, 8'h00, 24'hFFFFFF, 24'hABCDEF};
        next_cycle();
        in_valid = 1'b0;
        n_checks++;
        if (beat() !== exp_beat(1'b1, 1'b1, 1'b1, 3'd0, 3'd0)) begin
            n_fail++;
            $display("FAIL empty.beat: got %h expected %h", beat(), exp_beat(1'b1, 1'b1, 1'b1, 3'd0, 3'd0));
        end
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL empty.in_ready: got %b expected 1", in_ready);
        end
        next_cycle();
        n_checks++;
        if ({out_valid, busy} !== 2'b00) begin
            n_fail++;
            $display("FAIL empty.single: got %b expected 00", {out_valid, busy});
        end
    endtask

    // mask 0x81: slot0 (0,3), slot7 (5,6); middle slots hold decoys
    task automatic test_sparse();
        logic [8:0] exp [2];
        exp[0] = exp_beat(1'b1, 1'b0, 1'b0, 3'd0, 3'd3);
        exp[1] = exp_beat(1'b1, 1'b1, 1'b0, 3'd5, 3'd6);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_result = {8'h3C, 8'h81, {3'd6, 18'h15555, 3'd3}, {3'd5, 18'h2AAAA, 3'd0}};
        next_cycle();
        in_valid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (beat() !== exp[k]) begin
                n_fail++;
                $display("FAIL sparse.beat%0d: got %h expected %h", k, beat(), exp[k]);
            end
            next_cycle();
        end
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL sparse.end: got %b expected 0", out_valid);
        end
    endtask

    // A: act 1,2 wgt 3,4; B: act 5,6 wgt 7,0; both mask 0x03
    task automatic test_back_to_back();
        logic [8:0] exp [4];
        logic       exp_rdy [4];
        exp[0] = exp_beat(1'b1, 1'b0, 1'b0, 3'd1, 3'd3);
        exp[1] = exp_beat(1'b1, 1'b1, 1'b0, 3'd2, 3'd4);
        exp[2] = exp_beat(1'b1, 1'b0, 1'b0, 3'd5, 3'd7);
        exp[3] = exp_beat(1'b1, 1'b1, 1'b0, 3'd6, 3'd0);
        exp_rdy = '{1'b0, 1'b1, 1'b0, 1'b1};
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_result = {8'h00, 8'h03, {18'h0, 3'd4, 3'd3}, {18'h0, 3'd2, 3'd1}};
        next_cycle();
        in_result = {8'h5A, 8'h03, {18'h0, 3'd0, 3'd7}, {18'h0, 3'd6, 3'd5}};
        for (int k = 0; k < 4; k++) begin
            if (k >= 2) in_valid = 1'b0;
            n_checks++;
            if (beat() !== exp[k]) begin
                n_fail++;
                $display("FAIL b2b.beat%0d: got %h expected %h", k, beat(), exp[k]);
            end
            n_checks++;
            if (in_ready !== exp_rdy[k]) begin
                n_fail++;
                $display("FAIL b2b.in_ready%0d: got %b expected %b", k, in_ready, exp_rdy[k]);
            end
            next_cycle();
        end
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b.end: got %b expected 0", out_valid);
        end
    endtask

    task automatic test_stall();
        logic [8:0] exp [3];
        logic       pattern [12];
        logic [8:0] held;
        logic       stalled;
        int         idx;
        int         c;
        exp[0] = exp_beat(1'b1, 1'b0, 1'b0, 3'd1, 3'd2);
        exp[1] = exp_beat(1'b1, 1'b0, 1'b0, 3'd4, 3'd3);
        exp[2] = exp_beat(1'b1, 1'b1, 1'b0, 3'd6, 3'd7);
        pattern = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_result = {8'h11, 8'h07, {15'h0, 3'd7, 3'd3, 3'd2}, {15'h0, 3'd6, 3'd4, 3'd1}};
        next_cycle();
        in_valid = 1'b0;
        idx      = 0;
        c        = 0;
        stalled  = 1'b0;
        held     = '0;
        while (c < 12 && idx < 3) begin
            out_ready = pattern[c];
            if (stalled) begin
                n_checks++;
                if (beat() !== held) begin
                    n_fail++;
                    $display("FAIL stall.hold%0d: got %h expected %h", c, beat(), held);
                end
            end
            if (out_ready) begin
                n_checks++;
                if (beat() !== exp[idx]) begin
                    n_fail++;
                    $display("FAIL stall.beat%0d: got %h expected %h", idx, beat(), exp[idx]);
                end
                idx++;
            end
            stalled = !out_ready;
            held    = beat();
            next_cycle();
            c++;
        end
        out_ready = 1'b1;
        n_checks++;
        if (idx !== 3) begin
            n_fail++;
            $display("FAIL stall.count: got %0d expected 3", idx);
        end
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL stall.end: got %b expected 0", out_valid);
        end
    endtask

    // mask 0xFF, act slot i = i, wgt slot i = 7-i; reset after first beat
    task automatic test_reset_mid_emit();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_result = {8'h00, 8'hFF,
                     {3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7},
                     {3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0}};
        next_cycle();
        in_valid = 1'b0;
        n_checks++;
        if (beat() !== exp_beat(1'b1, 1'b0, 1'b0, 3'd0, 3'd7)) begin
            n_fail++;
            $display("FAIL rst_mid.beat0: got %h expected %h", beat(), exp_beat(1'b1, 1'b0, 1'b0, 3'd0, 3'd7));
        end
        next_cycle();
        #2 resetn = 1'b0;
        #1;
        n_checks++;
        if ({beat(), busy, in_ready} !== 11'h000) begin
            n_fail++;
            $display("FAIL rst_mid.async: got %h expected 000", {beat(), busy, in_ready});
        end
        #1 resetn = 1'b1;
        next_cycle();
        n_checks++;
        if ({out_valid, busy, in_ready} !== 3'b001) begin
            n_fail++;
            $display("FAIL rst_mid.idle: got %b expected 001", {out_valid, busy, in_ready});
        end
        in_valid  = 1'b1;
        in_result = {8'hEE, 8'h01, {21'h1FFFFF, 3'd5}, {21'h0, 3'd3}};
        next_cycle();
        in_valid = 1'b0;
        n_checks++;
        if (beat() !== exp_beat(1'b1, 1'b1, 1'b0, 3'd3, 3'd5)) begin
            n_fail++;
            $display("FAIL rst_mid.next: got %h expected %h", beat(), exp_beat(1'b1, 1'b1, 1'b0, 3'd3, 3'd5));
        end
        next_cycle();
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid.single: got %b expected 0", out_valid);
        end
    endtask

    initial begin
        test_reset();
        test_three_beats();
        test_empty();
        test_sparse();
        test_back_to_back();
        test_stall();
        test_reset_mid_emit();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
